// File: rtl/fbw_pattern_seq.sv
`default_nettype none
// ============================================================================
// fbw_pattern_seq : fills the panel back buffer with a test pattern, row by row
// Revision: 1.0
// ============================================================================
module fbw_pattern_seq #(
    parameter int N_ROWS     = 64,
    parameter int N_COLS     = 64,
    parameter int LOG_N_ROWS = $clog2(N_ROWS),
    parameter int LOG_N_COLS = $clog2(N_COLS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [23:0]           color,
    output logic                  busy,
    output logic [15:0]           frame_cnt,
    output logic [LOG_N_ROWS-1:0] fbw_row_addr,
    output logic                  fbw_row_store,
    input  logic                  fbw_row_rdy,
    output logic                  fbw_row_swap,
    output logic [23:0]           fbw_data,
    output logic [LOG_N_COLS-1:0] fbw_col_addr,
    output logic                  fbw_wren,
    output logic                  frame_swap,
    input  logic                  frame_rdy
);

    localparam logic [LOG_N_ROWS-1:0] C_LAST_ROW = LOG_N_ROWS'(N_ROWS - 1);
    localparam logic [LOG_N_COLS-1:0] C_LAST_COL = LOG_N_COLS'(N_COLS - 1);
    localparam int                    C_GSHIFT   = 8 - LOG_N_COLS;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        WAIT_ROW = 3'd2,
        STORE    = 3'd3,
        WAIT_FRM = 3'd4,
        SWAP     = 3'd5
    } state_t;

    state_t                r_state;
    logic [LOG_N_ROWS-1:0] r_row;
    logic [LOG_N_COLS-1:0] r_col;
    logic [1:0]            r_mode;
    logic [23:0]           r_color;

    logic                  w_row_b3;
    logic                  w_col_b3;
    logic [7:0]            w_grad;
    logic [23:0]           w_pixel;

    // Bit 3 of a narrow address does not exist and reads as zero.
    if (LOG_N_ROWS > 3) begin : g_row_b3
        assign w_row_b3 = r_row[3];
    end else begin : g_row_b3_zero
        assign w_row_b3 = 1'b0;
    end

    if (LOG_N_COLS > 3) begin : g_col_b3
        assign w_col_b3 = r_col[3];
    end else begin : g_col_b3_zero
        assign w_col_b3 = 1'b0;
    end

    always_comb begin
        w_grad  = 8'(8'(r_col) << C_GSHIFT);
        w_pixel = 24'h000000;
        case (r_mode)
            2'd0: w_pixel = r_color;
            2'd1: w_pixel = {w_grad, w_grad, w_grad};
            2'd2: w_pixel = (w_col_b3 ^ w_row_b3) ? 24'hFFFFFF : 24'h000000;
            default: w_pixel = (r_col == frame_cnt[LOG_N_COLS-1:0]) ? r_color : 24'h000000;
        endcase
    end

    // Outputs are registered from the current state, so every strobe trails
    // its state by one cycle while busy tracks the state register directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_row         <= '0;
            r_col         <= '0;
            r_mode        <= 2'd0;
            r_color       <= 24'h000000;
            busy          <= 1'b0;
            frame_cnt     <= 16'h0000;
            fbw_row_addr  <= '0;
            fbw_col_addr  <= '0;
            fbw_data      <= 24'h000000;
            fbw_wren      <= 1'b0;
            fbw_row_store <= 1'b0;
            fbw_row_swap  <= 1'b0;
            frame_swap    <= 1'b0;
        end else begin
            fbw_wren      <= 1'b0;
            fbw_row_store <= 1'b0;
            fbw_row_swap  <= 1'b0;
            frame_swap    <= 1'b0;
            fbw_data      <= 24'h000000;
            fbw_row_addr  <= r_row;
            fbw_col_addr  <= r_col;

            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_mode  <= mode;
                        r_color <= color;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_state <= WRITE;
                        busy    <= 1'b1;
                    end
                end
                WRITE: begin
                    fbw_wren <= 1'b1;
                    fbw_data <= w_pixel;
                    if (r_col == C_LAST_COL) begin
                        r_state <= WAIT_ROW;
                    end else begin
                        r_col <= r_col + LOG_N_COLS'(1);
                    end
                end
                WAIT_ROW: begin
                    if (fbw_row_rdy) begin
                        r_state <= STORE;
                    end
                end
                STORE: begin
                    fbw_row_store <= 1'b1;
                    fbw_row_swap  <= 1'b1;
                    if (r_row == C_LAST_ROW) begin
                        r_state <= WAIT_FRM;
                    end else begin
                        r_row   <= r_row + LOG_N_ROWS'(1);
                        r_col   <= '0;
                        r_state <= WRITE;
                    end
                end
                WAIT_FRM: begin
                    if (frame_rdy) begin
                        r_state <= SWAP;
                    end
                end
                SWAP: begin
                    frame_swap <= 1'b1;
                    frame_cnt  <= frame_cnt + 16'd1;
                    if (enable) begin
                        r_mode  <= mode;
                        r_color <= color;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_state <= WRITE;
                    end else begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fbw_pattern_seq.sv
`default_nettype none
// ============================================================================
// tb_fbw_pattern_seq : directed self-checking bench for fbw_pattern_seq
// Revision: 1.0
// ============================================================================
module tb_fbw_pattern_seq;

    localparam int NR = 16;
    localparam int NC = 64;

    logic        clk = 1'b0;
    logic        rst_n, enable, fbw_row_rdy, frame_rdy;
    logic [1:0]  mode;
    logic [23:0] color;
    logic        busy, fbw_row_store, fbw_row_swap, fbw_wren, frame_swap;
    logic [15:0] frame_cnt;
    logic [3:0]  fbw_row_addr;
    logic [5:0]  fbw_col_addr;
    logic [23:0] fbw_data;

    always #5 clk = ~clk;

    fbw_pattern_seq #(.N_ROWS(NR), .N_COLS(NC)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .color(color),
        .busy(busy), .frame_cnt(frame_cnt), .fbw_row_addr(fbw_row_addr),
        .fbw_row_store(fbw_row_store), .fbw_row_rdy(fbw_row_rdy),
        .fbw_row_swap(fbw_row_swap), .fbw_data(fbw_data),
        .fbw_col_addr(fbw_col_addr), .fbw_wren(fbw_wren),
        .frame_swap(frame_swap), .frame_rdy(frame_rdy)
    );

    int tests = 0, fails = 0;
    int n_wren = 0, n_store = 0, n_fswap = 0, n_strobe = 0, n_busy = 0;
    int data_err = 0, seq_err = 0, pulse_err = 0;
    int exp_col = 0, exp_srow = 0;
    logic prev_store = 1'b0, prev_fswap = 1'b0;
    logic [1:0]  exp_mode = 2'd0;
    logic [23:0] exp_color = 24'h0;
    logic [15:0] exp_fc = 16'h0;
    logic [23:0] cap_r0c5 = 24'h0, cap_r0c0 = 24'h0, cap_r8c0 = 24'h0;
    logic [23:0] cap_r0c2 = 24'h0, cap_r0c3 = 24'h0;

    function automatic logic [23:0] pat(input logic [1:0] m, input logic [23:0] col,
                                        input int r, input int c, input logic [15:0] fc);
        logic [7:0] g;
        g = 8'(c * 4);
        case (m)
            2'd0:    return col;
            2'd1:    return {g, g, g};
            2'd2:    return (((c / 8) % 2) != ((r / 8) % 2)) ? 24'hFFFFFF : 24'h0;
            default: return (c == int'(fc) % NC) ? col : 24'h0;
        endcase
    endfunction

    // Sampled on the active edge, so it sees the values of the cycle just ended.
    always @(posedge clk) begin
        if (fbw_wren) begin
            n_wren++;
            if (fbw_data !== pat(exp_mode, exp_color, int'(fbw_row_addr), int'(fbw_col_addr), exp_fc))
                data_err++;
            if (int'(fbw_col_addr) != exp_col) seq_err++;
            exp_col = (int'(fbw_col_addr) + 1) % NC;
            if (fbw_row_addr == 4'd0 && fbw_col_addr == 6'd5) cap_r0c5 = fbw_data;
            if (fbw_row_addr == 4'd0 && fbw_col_addr == 6'd0) cap_r0c0 = fbw_data;
            if (fbw_row_addr == 4'd8 && fbw_col_addr == 6'd0) cap_r8c0 = fbw_data;
            if (fbw_row_addr == 4'd0 && fbw_col_addr == 6'd2) cap_r0c2 = fbw_data;
            if (fbw_row_addr == 4'd0 && fbw_col_addr == 6'd3) cap_r0c3 = fbw_data;
        end
        if (!busy) exp_col = 0;
        if (fbw_row_store) begin
            n_store++;
            if (int'(fbw_row_addr) != exp_srow) seq_err++;
            exp_srow = (exp_srow + 1) % NR;
            if (!fbw_row_swap || fbw_wren) pulse_err++;
        end
        if (fbw_row_swap && !fbw_row_store) pulse_err++;
        if ((fbw_row_store && prev_store) || (frame_swap && prev_fswap)) pulse_err++;
        if (frame_swap) begin
            n_fswap++;
            exp_srow = 0;
        end
        if (fbw_wren || fbw_row_store || fbw_row_swap || frame_swap) n_strobe++;
        if (busy) n_busy++;
        prev_store = fbw_row_store;
        prev_fswap = frame_swap;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tmo(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: got timeout expected event", tag);
    endtask

    task automatic wait_cell(input int r, input int c, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(fbw_wren && int'(fbw_row_addr) == r && int'(fbw_col_addr) == c) && n < 3000);
        if (!(fbw_wren && int'(fbw_row_addr) == r && int'(fbw_col_addr) == c)) tmo(tag);
    endtask

    task automatic wait_store(input int r, input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(fbw_row_store && int'(fbw_row_addr) == r) && n < 3000);
        if (!(fbw_row_store && int'(fbw_row_addr) == r)) tmo(tag);
    endtask

    task automatic wait_fswap(input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_swap && n < 3000);
        if (!frame_swap) tmo(tag);
    endtask

    initial begin
        int n, w0, s0, f0, d0, e0, p0;
        rst_n = 1'b0; enable = 1'b1; mode = 2'd0; color = 24'h0;
        fbw_row_rdy = 1'b1; frame_rdy = 1'b1;

        // Reset with enable high, then idle with enable low
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_wren", fbw_wren, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_row_addr", fbw_row_addr, 0);
        chk("rst_col_addr", fbw_col_addr, 0);
        chk("rst_data", fbw_data, 0);
        chk("rst_pulses", {fbw_row_store, fbw_row_swap, frame_swap}, 0);
        enable = 1'b0; rst_n = 1'b1;
        s0 = n_strobe; w0 = n_busy;
        repeat (100) @(negedge clk);
        chk("idle_strobes", n_strobe - s0, 0);
        chk("idle_busy", n_busy - w0, 0);

        // Frame 1: solid colour, readies held high
        exp_mode = 2'd0; exp_color = 24'h123456; exp_fc = 16'd0;
        mode = 2'd0; color = 24'h123456;
        w0 = n_wren; s0 = n_store; f0 = n_fswap; d0 = data_err; e0 = seq_err; p0 = pulse_err;
        enable = 1'b1;
        @(negedge clk);
        chk("start_no_wren_yet", fbw_wren, 0);
        chk("start_busy", busy, 1);
        @(negedge clk);
        chk("first_wren", fbw_wren, 1);
        chk("first_col", fbw_col_addr, 0);
        enable = 1'b0;
        wait_fswap("f1_swap", n);
        chk("f1_length", n, 1057);
        chk("f1_busy_after", busy, 0);
        chk("f1_frame_cnt", frame_cnt, 1);
        @(negedge clk);
        chk("f1_wren_count", n_wren - w0, 1024);
        chk("f1_store_count", n_store - s0, 16);
        chk("f1_fswap_count", n_fswap - f0, 1);
        chk("f1_data_err", data_err - d0, 0);

        // Frame 2: gradient with row and frame stalls
        exp_mode = 2'd1; exp_fc = 16'd1; mode = 2'd1; color = 24'hABCDEF;
        w0 = n_wren; d0 = data_err;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        enable = 1'b0;
        wait_cell(3, 63, "f2_row3_end");
        fbw_row_rdy = 1'b0;
        @(negedge clk);
        s0 = n_wren;
        repeat (19) @(negedge clk);
        chk("stall_row_addr", fbw_row_addr, 3);
        fbw_row_rdy = 1'b1;
        wait_store(3, "f2_row3_store", n);
        chk("row_stall_tail", n, 2);
        chk("row_stall_no_wren", n_wren - s0, 0);
        wait_store(15, "f2_row15_store", n);
        frame_rdy = 1'b0;
        repeat (5) @(negedge clk);
        chk("frm_stall_no_swap", n_fswap - f0, 1);
        frame_rdy = 1'b1;
        wait_fswap("f2_swap", n);
        chk("frm_stall_tail", n, 2);
        chk("f2_frame_cnt", frame_cnt, 2);
        @(negedge clk);
        chk("grad_col5", cap_r0c5, 24'h141414);
        chk("f2_wren_count", n_wren - w0, 1024);
        chk("f2_data_err", data_err - d0, 0);

        // Frame 3: moving bar at frame_cnt 2, then back-to-back checker frame
        exp_mode = 2'd3; exp_fc = 16'd2; exp_color = 24'h00FF00;
        mode = 2'd3; color = 24'h00FF00;
        d0 = data_err;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        mode = 2'd2; color = 24'h0000FF;
        wait_fswap("f3_swap", n);
        exp_mode = 2'd2; exp_fc = 16'd3; exp_color = 24'h0000FF;
        enable = 1'b0;
        chk("f3_frame_cnt", frame_cnt, 3);
        chk("bar_col2", cap_r0c2, 24'h00FF00);
        chk("bar_col3", cap_r0c3, 24'h0);
        chk("f3_data_err", data_err - d0, 0);
        @(negedge clk);
        chk("b2b_first_wren", fbw_wren, 1);
        chk("b2b_first_col", fbw_col_addr, 0);
        d0 = data_err;
        wait_fswap("f4_swap", n);
        chk("f4_length", n, 1057);
        chk("f4_busy_after", busy, 0);
        @(negedge clk);
        chk("chk_r8c0", cap_r8c0, 24'hFFFFFF);
        chk("chk_r0c0", cap_r0c0, 24'h0);
        chk("f4_data_err", data_err - d0, 0);
        s0 = n_strobe;
        repeat (10) @(negedge clk);
        chk("f4_idle_strobes", n_strobe - s0, 0);

        // Frame 5: mode change and enable drop during row 2
        exp_mode = 2'd0; exp_color = 24'h654321; exp_fc = 16'd4;
        mode = 2'd0; color = 24'h654321;
        d0 = data_err; f0 = n_fswap;
        enable = 1'b1;
        wait_cell(2, 10, "f5_row2");
        mode = 2'd1; enable = 1'b0;
        wait_fswap("f5_swap", n);
        chk("f5_busy_after", busy, 0);
        chk("f5_frame_cnt", frame_cnt, 5);
        @(negedge clk);
        chk("f5_data_err", data_err - d0, 0);
        chk("f5_fswap_count", n_fswap - f0, 1);

        // Frame 6: reset during the col 3 write of row 0
        exp_mode = 2'd1; exp_fc = 16'd5;
        enable = 1'b1;
        wait_cell(0, 3, "f6_col3");
        rst_n = 1'b0; enable = 1'b0;
        @(negedge clk);
        chk("mid_rst_wren", fbw_wren, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_col", fbw_col_addr, 0);
        chk("mid_rst_data", fbw_data, 0);
        chk("mid_rst_frame_cnt", frame_cnt, 0);
        chk("mid_rst_pulses", {fbw_row_store, fbw_row_swap, frame_swap}, 0);
        rst_n = 1'b1;
        s0 = n_strobe;
        repeat (20) @(negedge clk);
        chk("post_rst_strobes", n_strobe - s0, 0);

        chk("col_row_sequence", seq_err - e0, 0);
        chk("pulse_shape", pulse_err - p0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fbw_pattern_seq.md
# fbw_pattern_seq

Frame-buffer write sequencer for the RGB panel: autonomously fills the panel back buffer with a selectable test pattern and walks the frame-buffer write handshake, one row at a time. It drives the same frame-buffer write port normally fed by the SPI video stream and sits beside it behind a port mux, for bring-up and standalone demo use. Per frame it writes every column of every row, stores and swaps each row, then requests a frame swap.

## Interface

Parameters:
- N_ROWS, 64, panel rows; power of 2, ≤256
- N_COLS, 64, panel columns; power of 2, ≤256
- LOG_N_ROWS, $clog2(N_ROWS), auto
- LOG_N_COLS, $clog2(N_COLS), auto

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  run request; level-sensitive
- mode  in  2  pattern select: 0 solid, 1 gradient, 2 checker, 3 moving bar
- color  in  24  solid/bar colour
- busy  out  1  high whenever state ≠ IDLE
- frame_cnt  out  16  completed frame swaps
- fbw_row_addr  out  LOG_N_ROWS  row being written/stored
- fbw_row_store  out  1  one-cycle row store pulse
- fbw_row_rdy  in  1  row store may be issued
- fbw_row_swap  out  1  one-cycle line-buffer swap pulse
- fbw_data  out  24  pixel data
- fbw_col_addr  out  LOG_N_COLS  pixel column
- fbw_wren  out  1  pixel write strobe
- frame_swap  out  1  one-cycle frame swap pulse
- frame_rdy  in  1  frame swap may be issued

## Operation

- Clocking and reset: one clock; reset is synchronous and active-low.
- All outputs are registered.
- Reset (rst_n low at a clk edge): state IDLE; all outputs 0, including frame_cnt, row/col addresses and all pulses. Applies mid-operation with no stray pulse afterwards.
- States: IDLE, WRITE, WAIT_ROW, STORE, WAIT_FRM, SWAP.
- IDLE: when enable is sampled high, latch mode and color, set row=0 and col=0, go to WRITE.
- WRITE: fbw_wren=1 every cycle, col 0..N_COLS-1 ascending, fbw_data per pattern. After col N_COLS-1, go to WAIT_ROW.
- WAIT_ROW: wren=0. Wait for fbw_row_rdy sampled high, then go to STORE.
- STORE: fbw_row_store=fbw_row_swap=1 for exactly one cycle, with fbw_row_addr=row.
  - If row = N_ROWS-1, go to WAIT_FRM.
  - Otherwise row+1, col=0, go to WRITE.
- WAIT_FRM: wait for frame_rdy sampled high, then go to SWAP.
- SWAP: frame_swap=1 for one cycle; frame_cnt+1, wrapping 0xFFFF→0.
  - If enable=1, re-latch mode and color, row=0, go to WRITE.
  - Otherwise go to IDLE.
- enable dropping mid-frame does not abort: the frame completes through SWAP, then the block returns to IDLE.
- mode and color changes mid-frame have no effect until the next frame start (no tearing).
- fbw_row_addr stays stable for a whole row, from WRITE through STORE.
- Patterns (c=col, r=row, 8-bit g = c << (8-LOG_N_COLS), truncated to 8 bits):
  - 0 (solid): color
  - 1 (gradient): {g,g,g}
  - 2 (checker): 24'hFFFFFF if c[3]^r[3], else 0 (bits above the width read as 0)
  - 3 (moving bar): color if c == frame_cnt[LOG_N_COLS-1:0], else 0
- fbw_row_rdy and frame_rdy are ignored outside WAIT_ROW and WAIT_FRM respectively.

## Timing

- enable sampled high in IDLE at edge k → first fbw_wren=1 (col 0) visible after edge k+1.
- fbw_data and fbw_col_addr are valid in the same cycle as fbw_wren.
- Per row: N_COLS wren cycles, then ≥1 WAIT_ROW cycle, then 1 STORE cycle.
  - Minimum N_COLS+2 cycles per row when fbw_row_rdy is held high.
- Minimum frame time: N_ROWS·(N_COLS+2)+2 cycles (WAIT_FRM and SWAP are 1 cycle each with frame_rdy high).
- Store, swap and frame pulses are never wider than one cycle. No wren occurs during STORE/WAIT/SWAP.
- Handshake inputs are level-sampled; a ready held low stalls indefinitely with outputs frozen and pulses at 0.

## Test plan

- Reset/idle: hold rst_n=0 for 3 cycles with enable=1 → all outputs 0. Release with enable=0 → busy stays 0, no strobes for 100 cycles.
- Solid frame, N_ROWS=N_COLS=8, rdys tied 1, mode=0, color=24'h123456:
  - 64 wren with data 24'h123456, cols 0..7 per row
  - 8 store+swap pulses, rows 0..7
  - 1 frame_swap; frame_cnt=1; frame length 8·10+2=82 cycles
- Stalls: hold fbw_row_rdy low for 20 cycles after row 3's writes → store delayed exactly 20 cycles, no extra wren. Hold frame_rdy low for 5 cycles → frame_swap delayed 5 cycles.
- Patterns, N_COLS=64:
  - mode=1 → col 5 data 24'h141414
  - mode=2 → row 8 col 0 data 24'hFFFFFF, row 0 col 0 data 0
  - mode=3 at frame_cnt=2 → only col 2 carries color
- Mid-frame changes: switch mode 0→1 and drop enable during row 2 → the frame stays solid and completes with frame_swap, then IDLE with busy=0.
- Wrap and reset mid-row:
  - Force frame_cnt=0xFFFF through one frame → reads 0.
  - Assert rst_n=0 during WRITE col 3 → next cycle all outputs 0, no store/swap pulse.
